m_spi_sequencer: RTL

M_SPI_SEQUENCER -- requirements
Module: m_spi_sequencer

---
 rtl/m_spi_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/m_spi_sequencer.sv
// Burst sequencer for an SPI master: launches WORDS 64-bit frames and checks
// the slave's one-frame-lagged echo. It reports pass/fail, a timeout abort and a saturating mismatch count.
module m_spi_sequencer #(
  parameter int unsigned WORDS      = 8,
  parameter int unsigned GAP_CYCLES = 27,
  parameter int unsigned TIMEOUT    = 65535,
  parameter logic [31:0] SEED       = 32'hA5C3_0F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        spi_ready,
  input  logic        spi_done,
  input  logic [63:0] spi_rx_data,
  output logic        spi_go,
  output logic [63:0] spi_tx_data,
  output logic        busy,
  output logic [7:0]  word_idx,
  output logic [7:0]  err_cnt,
  output logic        pass,
  output logic        fail,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(WORDS - 32'd1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 32'd1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic [15:0] wait_cnt_r, wait_cnt_s;
  logic [15:0] gap_cnt_r, gap_cnt_s;
  logic        go_s;
  logic [63:0] tx_s;
  logic        busy_s;
  logic [7:0]  idx_s;
  logic [7:0]  err_s;
  logic        pass_s;
  logic        fail_s;
  logic        tof_s;

  function automatic logic [63:0] tx_word(input logic [7:0] idx);
    return {SEED, 24'd0, idx};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    go_s       = 1'b0;
    tx_s       = spi_tx_data;
    idx_s      = word_idx;
    err_s      = err_cnt;
    pass_s     = pass;
    fail_s     = fail;
    tof_s      = timeout_flag;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          idx_s      = 8'd0;
          err_s      = 8'd0;
          pass_s     = 1'b0;
          fail_s     = 1'b0;
          tof_s      = 1'b0;
          tx_s       = tx_word(8'd0);
          wait_cnt_s = 16'd0;
          gap_cnt_s  = 16'd0;
          state_s    = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (spi_ready) begin
          go_s       = 1'b1;
          wait_cnt_s = 16'd0;
          state_s    = S_WAIT;
        end else begin
          state_s = S_LOAD;
        end
      end
      S_WAIT: begin
        if (spi_done) begin
          wait_cnt_s = 16'd0;
          // The slave echoes the previous frame, so frame 0 has nothing to check.
          if ((word_idx != 8'd0) && (spi_rx_data != tx_word(word_idx - 8'd1))) begin
            err_s = sat_inc(err_cnt);
          end else begin
            err_s = err_cnt;
          end
          if (word_idx == LAST_IDX) begin
            state_s = S_DONE;
          end else begin
            idx_s     = word_idx + 8'd1;
            gap_cnt_s = 16'd0;
            if (GAP_CYCLES == 32'd0) begin
              tx_s    = tx_word(word_idx + 8'd1);
              state_s = S_LOAD;
            end else begin
              state_s = S_GAP;
            end
          end
        end else if (wait_cnt_r == TO_LAST) begin
          tof_s      = 1'b1;
          fail_s     = 1'b1;
          wait_cnt_s = 16'd0;
          state_s    = S_IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_s = 16'd0;
          tx_s      = tx_word(word_idx);
          state_s   = S_LOAD;
        end else begin
          gap_cnt_s = gap_cnt_r + 16'd1;
        end
      end
      S_DONE: begin
        pass_s  = (err_cnt == 8'd0);
        fail_s  = (err_cnt != 8'd0);
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      wait_cnt_r   <= 16'd0;
      gap_cnt_r    <= 16'd0;
      spi_go       <= 1'b0;
      spi_tx_data  <= 64'd0;
      busy         <= 1'b0;
      word_idx     <= 8'd0;
      err_cnt      <= 8'd0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_cnt_r   <= wait_cnt_s;
      gap_cnt_r    <= gap_cnt_s;
      spi_go       <= go_s;
      spi_tx_data  <= tx_s;
      busy         <= busy_s;
      word_idx     <= idx_s;
      err_cnt      <= err_s;
      pass         <= pass_s;
      fail         <= fail_s;
      timeout_flag <= tof_s;
    end
  end

endmodule
